// File: rtl/wm8731_pkg.sv
// ============================================================================
//  Module   : wm8731_pkg
//  Purpose  : Shared audio types and receive state encoding for the WM8731 path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package wm8731_pkg;

    localparam int AUDIO_WIDTH = 16;

    typedef logic signed [AUDIO_WIDTH-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t left;
        audio_sample_t right;
    } audio_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ============================================================================
//  Module   : i2s_sync_edge
//  Purpose  : Equal-depth synchroniser for a small bus, plus per-bit rise and
//             toggle detection against a one-clock history flop.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_sync_edge #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_toggle
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync_q;
    logic [STAGES-1:0][WIDTH-1:0] w_sync_d;
    logic [WIDTH-1:0]             r_hist_q;

    always_comb begin
        w_sync_d[0] = i_d;
        for (int i = 1; i < STAGES; i++) begin
            w_sync_d[i] = r_sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= '0;
            r_hist_q <= '0;
        end else begin
            r_sync_q <= w_sync_d;
            r_hist_q <= r_sync_q[STAGES-1];
        end
    end

    assign o_sync   = r_sync_q[STAGES-1];
    assign o_rise   = o_sync & ~r_hist_q;
    assign o_toggle = o_sync ^ r_hist_q;

endmodule

`default_nettype wire

// File: rtl/i2s_adc_receiver.sv
// ============================================================================
//  Module   : i2s_adc_receiver
//  Purpose  : I2S (MSB first) ADC deserialiser presenting L/R pairs on a
//             valid/ready port. Define I2S_ADC_RECEIVER_MONO_EN for mono mix.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_adc_receiver
    import wm8731_pkg::*;
#(
    parameter int WIDTH       = AUDIO_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bclk,
    input  logic             adc_lr_ck,
    input  logic             adc_dat,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             locked
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);

    logic [2:0] w_sync, w_rise, w_toggle;
    logic       w_bclk_rise, w_lr, w_dat, w_lr_edge, w_unused_edges;

    i2s_sync_edge #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (reset),
        .i_d      ({bclk, adc_lr_ck, adc_dat}),
        .o_sync   (w_sync),
        .o_rise   (w_rise),
        .o_toggle (w_toggle)
    );

    assign w_bclk_rise    = w_rise[2];
    assign w_lr           = w_sync[1];
    assign w_dat          = w_sync[0];
    assign w_lr_edge      = w_bclk_rise & w_toggle[1];
    assign w_unused_edges = ^{w_sync[2], w_rise[1:0], w_toggle[2], w_toggle[0]};

    rx_state_t          r_state_q, w_state_d;
    logic               r_chan_q, w_chan_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d, w_cnt_inc;
    logic [WIDTH-1:0]   r_shift_q, w_shift_d, w_shift_nxt;
    logic [WIDTH-1:0]   r_left_hold_q, w_left_hold_d;
    logic               r_have_left_q, w_have_left_d;
    logic               w_pair_done, w_short;

    assign w_shift_nxt = {r_shift_q[WIDTH-2:0], w_dat};
    assign w_cnt_inc   = r_cnt_q + 1'b1;

    always_comb begin
        w_state_d     = r_state_q;
        w_chan_d      = r_chan_q;
        w_cnt_d       = r_cnt_q;
        w_shift_d     = r_shift_q;
        w_left_hold_d = r_left_hold_q;
        w_have_left_d = r_have_left_q;
        w_pair_done   = 1'b0;
        w_short       = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_lr_edge && !w_lr) begin
                    w_state_d     = DELAY;
                    w_chan_d      = 1'b0;
                    w_have_left_d = 1'b0;
                end
            end
            DELAY: begin
                if (w_bclk_rise) begin
                    w_cnt_d   = '0;
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A channel change before the word is full means we are misaligned.
                if (w_lr_edge) begin
                    w_short       = 1'b1;
                    w_have_left_d = 1'b0;
                    w_chan_d      = 1'b0;
                    w_state_d     = w_lr ? IDLE : DELAY;
                end else if (w_bclk_rise) begin
                    w_shift_d = w_shift_nxt;
                    w_cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == c_CNT_FULL) begin
                        w_state_d = WAIT;
                        if (!r_chan_q) begin
                            w_left_hold_d = w_shift_nxt;
                            w_have_left_d = 1'b1;
                        end else begin
                            w_pair_done   = r_have_left_q;
                            w_have_left_d = 1'b0;
                        end
                    end
                end
            end
            WAIT: begin
                if (w_lr_edge) begin
                    w_state_d = DELAY;
                    w_chan_d  = w_lr;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    logic             w_pair_in;
    logic [WIDTH-1:0] w_pair_l, w_pair_r;

`ifdef I2S_ADC_RECEIVER_MONO_EN
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_mono_q, w_mono_d;
    logic             r_mono_vld_q;

    // Sign-extended sum keeps the carry; dropping bit 0 is the arithmetic halve.
    assign w_sum    = {r_left_hold_q[WIDTH-1], r_left_hold_q} + {w_shift_nxt[WIDTH-1], w_shift_nxt};
    assign w_mono_d = w_sum[WIDTH:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mono_q     <= '0;
            r_mono_vld_q <= 1'b0;
        end else begin
            r_mono_q     <= w_mono_d;
            r_mono_vld_q <= w_pair_done;
        end
    end

    assign w_pair_in = r_mono_vld_q;
    assign w_pair_l  = r_mono_q;
    assign w_pair_r  = r_mono_q;
`else
    assign w_pair_in = w_pair_done;
    assign w_pair_l  = r_left_hold_q;
    assign w_pair_r  = w_shift_nxt;
`endif

    logic [WIDTH-1:0] r_left_q, w_left_d, r_right_q, w_right_d;
    logic             r_valid_q, w_valid_d, r_overrun_q, w_overrun_d, r_locked_q, w_locked_d;

    always_comb begin
        w_left_d    = r_left_q;
        w_right_d   = r_right_q;
        w_valid_d   = r_valid_q;
        w_overrun_d = r_overrun_q;
        w_locked_d  = r_locked_q;
        if (overrun_clr) w_overrun_d = 1'b0;
        if (w_short)     w_locked_d  = 1'b0;
        if (w_pair_in) begin
            if (!r_valid_q || ready) begin
                w_left_d   = w_pair_l;
                w_right_d  = w_pair_r;
                w_valid_d  = 1'b1;
                w_locked_d = 1'b1;
            end else begin
                w_overrun_d = 1'b1;
            end
        end else if (r_valid_q && ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_chan_q      <= 1'b0;
            r_cnt_q       <= '0;
            r_shift_q     <= '0;
            r_left_hold_q <= '0;
            r_have_left_q <= 1'b0;
            r_left_q      <= '0;
            r_right_q     <= '0;
            r_valid_q     <= 1'b0;
            r_overrun_q   <= 1'b0;
            r_locked_q    <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_chan_q      <= w_chan_d;
            r_cnt_q       <= w_cnt_d;
            r_shift_q     <= w_shift_d;
            r_left_hold_q <= w_left_hold_d;
            r_have_left_q <= w_have_left_d;
            r_left_q      <= w_left_d;
            r_right_q     <= w_right_d;
            r_valid_q     <= w_valid_d;
            r_overrun_q   <= w_overrun_d;
            r_locked_q    <= w_locked_d;
        end
    end

    assign left    = r_left_q;
    assign right   = r_right_q;
    assign valid   = r_valid_q;
    assign overrun = r_overrun_q;
    assign locked  = r_locked_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
// ============================================================================
//  Module   : tb_i2s_adc_receiver
//  Purpose  : Directed I2S frames with a queued scoreboard for i2s_adc_receiver.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        reset, bclk, adc_lr_ck, adc_dat, ready, overrun_clr;
    logic [15:0] left, right;
    logic        valid, overrun, locked;

    always #5 clk = ~clk;

    i2s_adc_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .bclk        (bclk),
        .adc_lr_ck   (adc_lr_ck),
        .adc_dat     (adc_dat),
        .left        (left),
        .right       (right),
        .valid       (valid),
        .ready       (ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .locked      (locked)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          s_lr[$];
    bit          s_dat[$];
    bit          s_mark[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pair(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_ADC_RECEIVER_MONO_EN
        logic [16:0] s;
        s = {l[15], l} + {r[15], r};
        return {s[16:1], s[16:1]};
`else
        return {l, r};
`endif
    endfunction

    // One entry per bclk rise of a slot; rise 0 carries the LR change, data bits at rises 2..17.
    task automatic push_slot(input bit lr, input logic [15:0] w, input int first, input int last, input bit mark);
        for (int k = first; k < last; k++) begin
            s_lr.push_back(lr);
            s_dat.push_back((k >= 2 && k < 18) ? w[17-k] : 1'b1);
            s_mark.push_back(mark && (k == 17));
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_out, input bit mark);
        push_slot(1'b0, l, 0, 32, 1'b0);
        push_slot(1'b1, r, 0, 32, mark);
        if (expect_out) exp_q.push_back(exp_pair(l, r));
    endtask

    // bclk = clk/5: high for 2 clocks, low for 3; data changes on the falling edge.
    task automatic drive_stream();
        bit m;
        if (s_lr.size() == 0) return;
        @(negedge clk) adc_dat = s_dat[0];
        for (int i = 0; i < s_lr.size(); i++) begin
            @(negedge clk);
            bclk      = 1'b1;
            adc_lr_ck = s_lr[i];
            m         = s_mark[i];
            @(negedge clk);
            @(negedge clk);
            bclk    = 1'b0;
            adc_dat = (i + 1 < s_lr.size()) ? s_dat[i+1] : 1'b1;
`ifndef I2S_ADC_RECEIVER_MONO_EN
            if (m) ready = 1'b1;
`endif
            @(negedge clk);
`ifdef I2S_ADC_RECEIVER_MONO_EN
            if (m) ready = 1'b1;
`else
            if (m) ready = 1'b0;
`endif
            @(negedge clk);
`ifdef I2S_ADC_RECEIVER_MONO_EN
            if (m) ready = 1'b0;
`endif
        end
        s_lr.delete();
        s_dat.delete();
        s_mark.delete();
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pair: got 0x%0h/0x%0h, expected none", left, right);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_left", {16'h0, left}, {16'h0, e[31:16]});
                    check("pair_right", {16'h0, right}, {16'h0, e[15:0]});
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        n_err++;
        $display("FAIL timeout: got no completion, expected end of test");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        logic [31:0] e;
        reset = 1'b1; bclk = 1'b0; adc_lr_ck = 1'b1; adc_dat = 1'b1;
        ready = 1'b0; overrun_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_left", {16'h0, left}, 32'h0);
        check("rst_right", {16'h0, right}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_locked", {31'h0, locked}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic capture, starting mid-way through a right slot
        ready = 1'b1;
        push_slot(1'b1, 16'hAAAA, 12, 32, 1'b0);
        push_frame(16'h8001, 16'h7FFE, 1'b1, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("basic_locked", {31'h0, locked}, 32'h1);
        check("basic_delivered", 32'(exp_q.size()), 32'h0);

        // Backpressure: second pair is dropped
        ready = 1'b0;
        push_frame(16'h1234, 16'h5678, 1'b1, 1'b0);
        push_frame(16'h1111, 16'h2222, 1'b0, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        e = exp_pair(16'h1234, 16'h5678);
        check("bp_valid", {31'h0, valid}, 32'h1);
        check("bp_overrun", {31'h0, overrun}, 32'h1);
        check("bp_left_held", {16'h0, left}, {16'h0, e[31:16]});
        check("bp_right_held", {16'h0, right}, {16'h0, e[15:0]});
        ready = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        #2;
        check("clr_valid", {31'h0, valid}, 32'h0);
        check("clr_overrun", {31'h0, overrun}, 32'h0);
        push_frame(16'h0ABC, 16'h0DEF, 1'b1, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("fresh_overrun", {31'h0, overrun}, 32'h0);
        check("fresh_delivered", 32'(exp_q.size()), 32'h0);

        // Accept of the old pair in the same cycle the new pair loads
        ready = 1'b0;
        push_frame(16'h3C3C, 16'hC3C3, 1'b1, 1'b0);
        push_frame(16'h5A5A, 16'hA5A5, 1'b1, 1'b1);
        drive_stream();
        repeat (10) @(negedge clk);
        check("simul_valid", {31'h0, valid}, 32'h1);
        check("simul_overrun", {31'h0, overrun}, 32'h0);
        check("simul_pending", 32'(exp_q.size()), 32'h1);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("simul_drained", 32'(exp_q.size()), 32'h0);

        // Short left word discards the frame and drops lock
        push_slot(1'b0, 16'h1357, 0, 10, 1'b0);
        push_slot(1'b1, 16'h2468, 0, 32, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("short_locked", {31'h0, locked}, 32'h0);
        check("short_valid", {31'h0, valid}, 32'h0);
        push_frame(16'h00FF, 16'hFF00, 1'b1, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("relock_locked", {31'h0, locked}, 32'h1);
        check("relock_delivered", 32'(exp_q.size()), 32'h0);

        // Reset after seven left bits
        e = exp_pair(16'h00FF, 16'hFF00);
        check("pre_rst_left", {16'h0, left}, {16'h0, e[31:16]});
        push_slot(1'b0, 16'hFFFF, 0, 9, 1'b0);
        drive_stream();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_left", {16'h0, left}, 32'h0);
        check("midrst_right", {16'h0, right}, 32'h0);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_locked", {31'h0, locked}, 32'h0);
        reset = 1'b0;
        push_slot(1'b0, 16'hFFFF, 9, 32, 1'b0);
        push_slot(1'b1, 16'hFFFF, 0, 32, 1'b0);
        push_frame(16'h7E57, 16'h0042, 1'b1, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("postrst_locked", {31'h0, locked}, 32'h1);
        check("postrst_delivered", 32'(exp_q.size()), 32'h0);

        // Sign handling and full-scale values
        push_frame(16'h4000, 16'hC000, 1'b1, 1'b0);
        push_frame(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        drive_stream();
        repeat (10) @(negedge clk);
        check("final_delivered", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_adc_receiver.md
Name: i2s_adc_receiver

Overview:
- Receive path of the WM8731 audio interface; counterpart to the DAC transmit path inside wm8731_controller.
- The codec runs in slave mode. wm8731_controller sources bclk and the ADC LR clock. This block deserialises AUD_ADCDAT (I2S, MSB first) into parallel left/right sample pairs.
- Pairs are presented on a valid/ready port in the clk240m domain, for loopback tests and a future transmit/RDS path.

Parameters:
- WIDTH, 16: sample width in bits captured per channel.
- SYNC_STAGES, 2: synchroniser depth. Applied identically to bclk, adc_lr_ck and adc_dat so that their relative alignment is kept.

Ports:
- clk, input, 1: system clock (clk240m).
- reset, input, 1: synchronous, active-high reset.
- bclk, input, 1: I2S bit clock from the controller; level signal, oversampled by clk.
- adc_lr_ck, input, 1: ADC LR clock. 0 = left, 1 = right.
- adc_dat, input, 1: serial ADC data from the codec.
- left, output, WIDTH: left sample, two's complement.
- right, output, WIDTH: right sample, two's complement.
- valid, output, 1: left/right hold an unconsumed pair.
- ready, input, 1: consumer accepts the pair when valid && ready.
- overrun, output, 1: sticky; a completed pair was dropped.
- overrun_clr, input, 1: clears overrun.
- locked, output, 1: at least one aligned pair has been captured since reset.

Behaviour:
- Synchronisation and edge detection
  - All three inputs pass through SYNC_STAGES flops, followed by one history flop.
  - bclk_rise = sync && !hist. lr_edge = sync != hist, sampled only on bclk_rise cycles.
  - Data is sampled only on bclk_rise.
- State machine: IDLE, DELAY, SHIFT, WAIT.
  - IDLE: wait for an lr_edge to 0 (start of left). Go to DELAY.
  - DELAY: consume the I2S one-bit delay, i.e. the next bclk_rise. Clear bit counter. Go to SHIFT.
  - SHIFT: on each bclk_rise shift adc_dat into the channel shift register, MSB first, and increment the counter. At count == WIDTH, store the word into the channel holding register and go to WAIT.
  - WAIT: ignore the remaining bits (codec slot may exceed WIDTH). On lr_edge go to DELAY and switch channel.
- Short word: an lr_edge while in SHIFT with count < WIDTH.
  - The current pair is discarded and locked is cleared.
  - On an edge to 0, resume at DELAY for left. Otherwise go to IDLE.
- Pair completion: the right word is stored while the left word is held from the same frame.
  - If valid == 0, or valid && ready in the same cycle: load left/right, set valid = 1, set locked = 1.
  - If valid && !ready: drop the new pair, keep the old pair, set overrun = 1.
- valid clears on valid && ready unless a new pair loads in that same cycle.
- Latency: valid rises exactly 1 clk after the clk in which the WIDTH-th right bit is sampled. Add SYNC_STAGES+1 clk from the pin.
- overrun priority: set beats clear if overrun_clr coincides with a drop.
- Reset
  - Outputs: left = 0, right = 0, valid = 0, overrun = 0, locked = 0.
  - Internal: state = IDLE, synchronisers = 0.
  - Reset mid-frame abandons the partial word. Capture restarts only at the next lr_edge to 0.
- bclk stopped: state holds indefinitely. No timeout.

Optional Feature:
- Macro: I2S_ADC_RECEIVER_MONO_EN.
- Defined:
  - left = right = arithmetic mean of the captured pair: (L + R) >>> 1, computed at WIDTH+1 bits and truncated to WIDTH.
  - Adds one pipeline register, so latency increases by 1 clk. valid is delayed to match.
  - Overrun still applies.
- Undefined: stereo pass-through as above, with no extra register.

Decomposition:
- Package wm8731_pkg:
  - Constant AUDIO_WIDTH = 16.
  - Typedef audio_sample_t, logic signed [AUDIO_WIDTH-1:0].
  - Typedef packed struct audio_pair_t {left, right}.
  - Enum rx_state_t {IDLE, DELAY, SHIFT, WAIT}.
- Sub-module i2s_sync_edge:
  - Parameterised-depth synchroniser plus rise/toggle detect for a 3-bit bus {bclk, adc_lr_ck, adc_dat}.
  - Reusable by a future I2S slave DAC path.

Test Plan:
- Basic capture: bclk = clk/5, 32-bit slots, pair L = 0x8001, R = 0x7FFE. Expect valid with left = 0x8001, right = 0x7FFE; locked = 1.
- Backpressure and overrun:
  - ready = 0 for two frames: L/R = 0x1234/0x5678 then 0x1111/0x2222. Expect outputs to stay 0x1234/0x5678 and overrun = 1.
  - Then ready = 1 and overrun_clr for 1 clk. Expect valid = 0, then the next frame delivers a fresh pair with overrun = 0.
- Simultaneous accept and complete: ready asserted in exactly the load cycle of the second pair. Expect the second pair loaded, valid stays 1, overrun stays 0.
- Short word and start alignment:
  - Left slot truncated to 10 bits. Expect no valid for that frame and locked = 0; the next full frame 0x00FF/0xFF00 is captured correctly.
  - Start stimulus mid-right-slot. Expect the first pair to come from the following left slot.
- Reset mid-frame: assert reset after 7 left bits. Expect all outputs 0 next clk, and the first valid pair to come from the next complete frame.
- Mono variant (I2S_ADC_RECEIVER_MONO_EN): L = 0x4000, R = 0xC000. Expect left = right = 0x0000. L = 0x7FFF, R = 0x7FFF: expect 0x7FFF. Latency is +1 clk versus stereo.
